mem_port_arbiter: RTL and testbench

- Sequences the single main-memory port between the I-cache refill path and the D-cache refill/write-back path.
- Sits between both caches and the memory model.
- Exports busy/done status that drives instruction_not_ready, d_cache_miss and enable_write_from_cache_to_memory in the pipeline stall logic.
- Memory is fixed-latency with no handshake; the arbiter holds address, data and enable stable for MEM_LATENCY cycles and captures the line itself.

---
 rtl/mem_port_arbiter_if.sv | 61 ++++++
 rtl/mem_port_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the I-cache, D-cache and main-memory signals around the memory
// port arbiter.
//   slave  : arbiter side (takes requests and mem_rdata, drives
//            done/rdata and the memory bus)
//   master : cache/memory side (drives requests and mem_rdata)
// Signals
//   ic_req/ic_addr/ic_abort   I-cache line read request
//   ic_done/ic_rdata          I-cache completion pulse and returned line
//   dc_req/dc_we/dc_addr/
//   dc_wdata                  D-cache refill (we=0) or write-back (we=1)
//   dc_done/dc_rdata          D-cache completion pulse and returned line
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata       fixed-latency memory port
//   mem_busy                  arbiter not idle
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_abort;
  logic              ic_done;
  logic [LINE_W-1:0] ic_rdata;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic              dc_done;
  logic [LINE_W-1:0] dc_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_busy;

  modport slave (
    input  ic_req, ic_addr, ic_abort,
    output ic_done, ic_rdata,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    output dc_done, dc_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_busy,
    input  mem_rdata
  );

  modport master (
    output ic_req, ic_addr, ic_abort,
    input  ic_done, ic_rdata,
    output dc_req, dc_we, dc_addr, dc_wdata,
    input  dc_done, dc_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_busy,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single fixed-latency main-memory port between the I-cache
// refill path and the D-cache refill/write-back path. The memory has no
// handshake: the arbiter holds address, data and enable for MEM_LATENCY
// cycles and captures mem_rdata in the last access cycle itself.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_port_arbiter_if.slave (cache requests, done/rdata, memory bus)
//
// Parameters
//   ADDR_W       byte address width
//   LINE_W       cache line width
//   MEM_LATENCY  access cycles, 1..255
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no access; arbitrate between ic_req and dc_req at the edge
// IC_RD | I-cache line read on the memory port (abortable)
// DC_RD | D-cache refill read on the memory port
// DC_WR | D-cache write-back on the memory port
// DONE  | one-cycle done pulse to the served requester, port idle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int MEM_LATENCY = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IC_RD = 3'd1,
    DC_RD = 3'd2,
    DC_WR = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(MEM_LATENCY - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              last_dc_q;
  logic              wb_hold_q;
  logic              done_dc_q;
  logic [LINE_W-1:0] ic_rdata_q;
  logic [LINE_W-1:0] dc_rdata_q;

  logic              ic_ok;
  logic              dc_win;
  logic              cap_ic;
  logic              cap_dc;
  logic              fin_wr;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;

  // An aborting I-cache request never competes for the port.
  assign ic_ok = bus.ic_req & ~bus.ic_abort;

  // DC wins unless IC is waiting and DC was served last; a refill right
  // after a write-back (wb_hold) still beats IC once.
  assign dc_win = bus.dc_req & (~ic_ok | wb_hold_q | ~last_dc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_ic  = 1'b0;
    cap_dc  = 1'b0;
    fin_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dc_win) begin
          state_d = bus.dc_we ? DC_WR : DC_RD;
          cnt_d   = CNT_LOAD;
        end else if (ic_ok) begin
          state_d = IC_RD;
          cnt_d   = CNT_LOAD;
        end
      end
      IC_RD: begin
        // Abort takes priority over a capture in the same cycle.
        if (bus.ic_abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 8'd0) begin
          state_d = DONE;
          cap_ic  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DC_RD: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
          cap_dc  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DC_WR: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
          fin_wr  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Completion bookkeeping: line capture, who gets the done pulse, and
  // the fairness flags. All of it updates on the edge entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dc_q  <= 1'b0;
      wb_hold_q  <= 1'b0;
      done_dc_q  <= 1'b0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else begin
      if (cap_ic) begin
        ic_rdata_q <= bus.mem_rdata;
        last_dc_q  <= 1'b0;
        done_dc_q  <= 1'b0;
      end
      if (cap_dc) begin
        dc_rdata_q <= bus.mem_rdata;
        last_dc_q  <= 1'b1;
        done_dc_q  <= 1'b1;
      end
      if (fin_wr) begin
        last_dc_q <= 1'b1;
        done_dc_q <= 1'b1;
        wb_hold_q <= 1'b1;
      end else if (state_q == IDLE) begin
        // wb_hold covers exactly one arbitration after a write-back.
        wb_hold_q <= 1'b0;
      end
    end
  end

  // Memory bus is zero outside the access states.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IC_RD: begin
        mem_en   = 1'b1;
        mem_addr = bus.ic_addr;
      end
      DC_RD: begin
        mem_en   = 1'b1;
        mem_addr = bus.dc_addr;
      end
      DC_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = bus.dc_addr;
        mem_wdata = bus.dc_wdata;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_busy  = (state_q != IDLE);

  assign bus.ic_done   = (state_q == DONE) & ~done_dc_q;
  assign bus.dc_done   = (state_q == DONE) &  done_dc_q;
  assign bus.ic_rdata  = ic_rdata_q;
  assign bus.dc_rdata  = dc_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  localparam logic [LW-1:0] PAT_1 = {16{8'hA5}};
  localparam logic [LW-1:0] PAT_2 = {4{32'hDEADBEEF}};
  localparam logic [LW-1:0] PAT_3 = {4{32'h0BADF00D}};
  localparam logic [LW-1:0] PAT_4 = {4{32'h12345678}};
  localparam logic [LW-1:0] PAT_5 = {4{32'hCAFEF00D}};
  localparam logic [LW-1:0] PAT_6 = {4{32'h600DD00D}};

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus1 ();

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(10)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   glog [8];
  int   n_grant;
  logic prev_en;
  int   ic_dn, dc_dn, wr_cyc, dn_at;

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // grant codes: 1 = IC read, 2 = DC read, 3 = DC write
  task automatic log_grant();
    if (bus0.mem_en && !prev_en && n_grant < 8) begin
      if (bus0.mem_we)
        glog[n_grant] = 3;
      else if (bus0.mem_addr == bus0.dc_addr)
        glog[n_grant] = 2;
      else if (bus0.mem_addr == bus0.ic_addr)
        glog[n_grant] = 1;
      else
        glog[n_grant] = 0;
      n_grant++;
    end
    prev_en = bus0.mem_en;
  endtask

  task automatic clear_log();
    n_grant = 0;
    prev_en = 1'b0;
    for (int i = 0; i < 8; i++) glog[i] = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.ic_req = 0; bus0.ic_addr = '0; bus0.ic_abort = 0;
    bus0.dc_req = 0; bus0.dc_we = 0; bus0.dc_addr = '0; bus0.dc_wdata = '0;
    bus0.mem_rdata = '0;
    bus1.ic_req = 0; bus1.ic_addr = '0; bus1.ic_abort = 0;
    bus1.dc_req = 0; bus1.dc_we = 0; bus1.dc_addr = '0; bus1.dc_wdata = '0;
    bus1.mem_rdata = '0;
    clear_log();

    // reset state
    @(negedge clk);
    check_val("rst_mem_en",   128'(bus0.mem_en),    128'(0));
    check_val("rst_mem_busy", 128'(bus0.mem_busy),  128'(0));
    check_val("rst_mem_we",   128'(bus0.mem_we),    128'(0));
    check_val("rst_mem_addr", 128'(bus0.mem_addr),  128'(0));
    check_val("rst_wdata",    bus0.mem_wdata,       128'(0));
    check_val("rst_ic_done",  128'(bus0.ic_done),   128'(0));
    check_val("rst_dc_done",  128'(bus0.dc_done),   128'(0));
    check_val("rst_ic_rdata", bus0.ic_rdata,        128'(0));
    check_val("rst_dc_rdata", bus0.dc_rdata,        128'(0));
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // T1: single IC read, latency 10
    bus0.mem_rdata = PAT_1;
    bus0.ic_addr   = 32'h40;
    bus0.ic_req    = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      check_val($sformatf("t1_en_c%0d", c),   128'(bus0.mem_en),   128'(c <= 10));
      check_val($sformatf("t1_addr_c%0d", c), 128'(bus0.mem_addr), (c <= 10) ? 128'h40 : 128'h0);
      check_val($sformatf("t1_done_c%0d", c), 128'(bus0.ic_done),  128'(c == 11));
      check_val($sformatf("t1_busy_c%0d", c), 128'(bus0.mem_busy), 128'(c <= 11));
      if (c == 11) begin
        check_val("t1_ic_rdata", bus0.ic_rdata, PAT_1);
        bus0.ic_req = 1'b0;
      end
    end

    // T2: write-back then refill while IC waits
    clear_log();
    ic_dn = 0; dc_dn = 0; wr_cyc = 0;
    bus0.mem_rdata = PAT_2;
    bus0.ic_addr   = 32'h80;
    bus0.ic_req    = 1'b1;
    bus0.dc_addr   = 32'h100;
    bus0.dc_wdata  = 128'h1234;
    bus0.dc_we     = 1'b1;
    bus0.dc_req    = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      if (bus0.mem_en && !prev_en && bus0.mem_we)
        check_val("t2_wdata", bus0.mem_wdata, 128'h1234);
      log_grant();
      if (bus0.mem_we) wr_cyc++;
      if (bus0.dc_done) begin
        dc_dn++;
        if (bus0.dc_we) begin
          bus0.dc_we = 1'b0;
        end else begin
          check_val("t2_dc_rdata", bus0.dc_rdata, PAT_2);
          bus0.dc_req = 1'b0;
        end
      end
      if (bus0.ic_done) begin
        ic_dn++;
        check_val("t2_ic_rdata", bus0.ic_rdata, PAT_2);
        bus0.ic_req = 1'b0;
      end
    end
    check_val("t2_n_grant", 128'(n_grant), 128'(3));
    check_val("t2_grant0",  128'(glog[0]), 128'(3));
    check_val("t2_grant1",  128'(glog[1]), 128'(2));
    check_val("t2_grant2",  128'(glog[2]), 128'(1));
    check_val("t2_wr_cyc",  128'(wr_cyc),  128'(10));
    check_val("t2_dc_dn",   128'(dc_dn),   128'(2));
    check_val("t2_ic_dn",   128'(ic_dn),   128'(1));

    // T3: both held from reset -> DC, IC, DC, IC
    rst_n = 1'b0;
    clear_log();
    ic_dn = 0; dc_dn = 0;
    bus0.mem_rdata = PAT_3;
    bus0.ic_addr   = 32'h300;
    bus0.ic_req    = 1'b1;
    bus0.dc_addr   = 32'h200;
    bus0.dc_we     = 1'b0;
    bus0.dc_req    = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      next_cycle();
      log_grant();
      if (bus0.dc_done) dc_dn++;
      if (bus0.ic_done) ic_dn++;
      if (ic_dn + dc_dn == 4) begin
        bus0.ic_req = 1'b0;
        bus0.dc_req = 1'b0;
        break;
      end
    end
    check_val("t3_n_grant", 128'(n_grant), 128'(4));
    check_val("t3_grant0",  128'(glog[0]), 128'(2));
    check_val("t3_grant1",  128'(glog[1]), 128'(1));
    check_val("t3_grant2",  128'(glog[2]), 128'(2));
    check_val("t3_grant3",  128'(glog[3]), 128'(1));
    check_val("t3_dc_dn",   128'(dc_dn),   128'(2));
    check_val("t3_ic_dn",   128'(ic_dn),   128'(2));
    next_cycle();

    // T4: abort IC in 4th access cycle, pending DC then granted
    ic_dn = 0; dn_at = 0;
    bus0.mem_rdata = PAT_4;
    bus0.ic_addr   = 32'h40;
    bus0.ic_req    = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      if (bus0.ic_done) ic_dn++;
      if (c == 2) begin
        bus0.dc_addr = 32'h100;
        bus0.dc_we   = 1'b0;
        bus0.dc_req  = 1'b1;
      end
      if (c == 4) begin
        check_val("t4_en_c4",   128'(bus0.mem_en),   128'(1));
        check_val("t4_addr_c4", 128'(bus0.mem_addr), 128'h40);
        bus0.ic_abort = 1'b1;
      end
      if (c == 5) begin
        check_val("t4_en_c5",   128'(bus0.mem_en),   128'(0));
        check_val("t4_busy_c5", 128'(bus0.mem_busy), 128'(0));
        bus0.ic_abort = 1'b0;
        bus0.ic_req   = 1'b0;
      end
      if (c == 6) begin
        check_val("t4_en_c6",   128'(bus0.mem_en),   128'(1));
        check_val("t4_addr_c6", 128'(bus0.mem_addr), 128'h100);
        check_val("t4_we_c6",   128'(bus0.mem_we),   128'(0));
      end
      if (bus0.dc_done) begin
        if (dn_at == 0) dn_at = c;
        bus0.dc_req = 1'b0;
      end
    end
    check_val("t4_ic_dn",    128'(ic_dn),   128'(0));
    check_val("t4_ic_rdata", bus0.ic_rdata, PAT_3);
    check_val("t4_dc_at",    128'(dn_at),   128'(16));
    check_val("t4_dc_rdata", bus0.dc_rdata, PAT_4);

    // T5: reset in access cycle 5 of DC_RD
    bus0.mem_rdata = PAT_5;
    bus0.dc_addr   = 32'h180;
    bus0.dc_we     = 1'b0;
    bus0.dc_req    = 1'b1;
    for (int c = 1; c <= 5; c++) next_cycle();
    check_val("t5_en_c5", 128'(bus0.mem_en), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    check_val("t5_rst_en",       128'(bus0.mem_en),   128'(0));
    check_val("t5_rst_busy",     128'(bus0.mem_busy), 128'(0));
    check_val("t5_rst_addr",     128'(bus0.mem_addr), 128'(0));
    check_val("t5_rst_dc_done",  128'(bus0.dc_done),  128'(0));
    check_val("t5_rst_dc_rdata", bus0.dc_rdata,       128'(0));
    check_val("t5_rst_ic_rdata", bus0.ic_rdata,       128'(0));
    next_cycle();
    check_val("t5_rst_hold_done", 128'(bus0.dc_done), 128'(0));
    rst_n = 1'b1;
    dc_dn = 0; dn_at = 0;
    for (int i = 1; i <= 14; i++) begin
      next_cycle();
      if (bus0.dc_done) begin
        dc_dn++;
        if (dn_at == 0) dn_at = i;
        bus0.dc_req = 1'b0;
      end
    end
    check_val("t5_dc_at",    128'(dn_at),   128'(11));
    check_val("t5_dc_dn",    128'(dc_dn),   128'(1));
    check_val("t5_dc_rdata", bus0.dc_rdata, PAT_5);

    // T6: MEM_LATENCY=1, back-to-back IC reads, 3-cycle cadence
    bus1.mem_rdata = PAT_6;
    bus1.ic_addr   = 32'h20;
    bus1.ic_req    = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      check_val($sformatf("t6_en_c%0d", c),   128'(bus1.mem_en),   128'(c % 3 == 1));
      check_val($sformatf("t6_done_c%0d", c), 128'(bus1.ic_done),  128'(c % 3 == 2));
      check_val($sformatf("t6_busy_c%0d", c), 128'(bus1.mem_busy), 128'(c % 3 != 0));
      check_val($sformatf("t6_addr_c%0d", c), 128'(bus1.mem_addr),
                (c % 3 == 1) ? 128'h20 : 128'h0);
      if (c == 9) bus1.ic_req = 1'b0;
    end
    check_val("t6_ic_rdata", bus1.ic_rdata, PAT_6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
